// File: rtl/pw_sequence_detector_if.sv
// Keypad-side bundle for the password sequence detector: digit strobes in, verdict and status out.
interface pw_sequence_detector_if #(
   parameter int unsigned PW_LEN    = 4,
   parameter int unsigned DIGIT_W   = 4,
   parameter int unsigned MAX_FAILS = 3
);
   localparam int unsigned CntW  = $clog2(PW_LEN + 1);
   localparam int unsigned FailW = $clog2(MAX_FAILS + 1);

   logic               digit_valid;
   logic [DIGIT_W-1:0] digit;
   logic               clear;
   logic               match_pulse;
   logic               fail_pulse;
   logic               locked;
   logic [CntW-1:0]    digit_count;
   logic [FailW-1:0]   fail_count;

   modport master (
      output digit_valid, digit, clear,
      input  match_pulse, fail_pulse, locked, digit_count, fail_count
   );

   modport slave (
      input  digit_valid, digit, clear,
      output match_pulse, fail_pulse, locked, digit_count, fail_count
   );
endinterface

// File: rtl/pw_sequence_detector.sv
// Password sequence detector: collects PW_LEN digits, pulses match/fail, and enforces a timed
// lockout after MAX_FAILS consecutive failures.
module pw_sequence_detector #(
   parameter int unsigned                 PW_LEN         = 4,
   parameter int unsigned                 DIGIT_W        = 4,
   parameter logic [PW_LEN*DIGIT_W-1:0]   PASSWORD       = 16'h1234,
   parameter int unsigned                 MAX_FAILS      = 3,
   parameter int unsigned                 LOCKOUT_CYCLES = 1000,
   parameter int unsigned                 ENTRY_TIMEOUT  = 500
) (
   input logic                     clk,
   input logic                     countReset,
   pw_sequence_detector_if.slave   bus
);
   localparam int unsigned CntW  = $clog2(PW_LEN + 1);
   localparam int unsigned FailW = $clog2(MAX_FAILS + 1);
   localparam int unsigned TmoW  = $clog2(ENTRY_TIMEOUT + 1);
   localparam int unsigned LockW = $clog2(LOCKOUT_CYCLES + 1);

   localparam logic [CntW-1:0]  LastCnt  = CntW'(PW_LEN - 1);
   localparam logic [FailW-1:0] FailLast = FailW'(MAX_FAILS - 1);
   localparam logic [FailW-1:0] FailMax  = FailW'(MAX_FAILS);
   localparam logic [TmoW-1:0]  TmoLast  = TmoW'(ENTRY_TIMEOUT - 1);
   localparam logic [LockW-1:0] LockLast = LockW'(LOCKOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StEntry, StCheck, StLockout} state_e;

   state_e             state_q;
   logic [CntW-1:0]    count_q;
   logic [FailW-1:0]   fails_q;
   logic [TmoW-1:0]    tmo_q;
   logic [LockW-1:0]   lock_q;
   logic               mismatch_q;
   logic               match_q;
   logic               fail_q;
   logic               locked_q;
   logic [DIGIT_W-1:0] exp_digit;

   // Count is 0 in IDLE, so the same lookup serves the first digit and later ones.
   always_comb begin
      exp_digit = '0;
      for (int i = 0; i < int'(PW_LEN); i++) begin
         if (count_q == CntW'(i)) begin
            exp_digit = PASSWORD[DIGIT_W*(int'(PW_LEN)-1-i) +: DIGIT_W];
         end
      end
   end

   always_ff @(posedge clk or posedge countReset) begin
      if (countReset) begin
         state_q    <= StIdle;
         count_q    <= '0;
         fails_q    <= '0;
         tmo_q      <= '0;
         lock_q     <= '0;
         mismatch_q <= 1'b0;
         match_q    <= 1'b0;
         fail_q     <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         match_q <= 1'b0;
         fail_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.clear) begin
                  count_q    <= '0;
                  mismatch_q <= 1'b0;
                  tmo_q      <= '0;
               end else if (bus.digit_valid) begin
                  mismatch_q <= (bus.digit != exp_digit);
                  count_q    <= CntW'(1);
                  tmo_q      <= '0;
                  state_q    <= (PW_LEN == 1) ? StCheck : StEntry;
               end
            end
            StEntry: begin
               if (bus.clear) begin
                  count_q    <= '0;
                  mismatch_q <= 1'b0;
                  tmo_q      <= '0;
                  state_q    <= StIdle;
               end else if (bus.digit_valid) begin
                  mismatch_q <= mismatch_q | (bus.digit != exp_digit);
                  count_q    <= count_q + CntW'(1);
                  tmo_q      <= '0;
                  if (count_q == LastCnt) state_q <= StCheck;
               end else if (tmo_q == TmoLast) begin
                  // Abandoned partial entry: no fail is recorded.
                  count_q    <= '0;
                  mismatch_q <= 1'b0;
                  tmo_q      <= '0;
                  state_q    <= StIdle;
               end else begin
                  tmo_q <= tmo_q + TmoW'(1);
               end
            end
            StCheck: begin
               count_q    <= '0;
               mismatch_q <= 1'b0;
               tmo_q      <= '0;
               if (!mismatch_q) begin
                  match_q <= 1'b1;
                  fails_q <= '0;
                  state_q <= StIdle;
               end else begin
                  fail_q <= 1'b1;
                  if (fails_q >= FailLast) begin
                     fails_q  <= FailMax;
                     locked_q <= 1'b1;
                     lock_q   <= '0;
                     state_q  <= StLockout;
                  end else begin
                     fails_q <= fails_q + FailW'(1);
                     state_q <= StIdle;
                  end
               end
            end
            StLockout: begin
               if (lock_q == LockLast) begin
                  locked_q <= 1'b0;
                  fails_q  <= '0;
                  lock_q   <= '0;
                  state_q  <= StIdle;
               end else begin
                  lock_q <= lock_q + LockW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.match_pulse = match_q;
   assign bus.fail_pulse  = fail_q;
   assign bus.locked      = locked_q;
   assign bus.digit_count = count_q;
   assign bus.fail_count  = fails_q;
endmodule

// File: tb/tb_pw_sequence_detector.sv
// Directed bench for pw_sequence_detector: an entry-level behavioural model checked every cycle,
// plus hand-computed literal checks along the directed scenarios.
module tb_pw_sequence_detector;
   localparam int unsigned PW_LEN         = 4;
   localparam int unsigned DIGIT_W        = 4;
   localparam logic [15:0] PASSWORD       = 16'h1234;
   localparam int unsigned MAX_FAILS      = 3;
   localparam int unsigned LOCKOUT_CYCLES = 1000;
   localparam int unsigned ENTRY_TIMEOUT  = 500;

   logic clk = 1'b0;
   logic countReset = 1'b1;

   pw_sequence_detector_if #(.PW_LEN(PW_LEN), .DIGIT_W(DIGIT_W), .MAX_FAILS(MAX_FAILS)) bus ();

   pw_sequence_detector #(
      .PW_LEN(PW_LEN), .DIGIT_W(DIGIT_W), .PASSWORD(PASSWORD), .MAX_FAILS(MAX_FAILS),
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
   ) dut (
      .clk(clk),
      .countReset(countReset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an entry is a list of digits; the verdict comes one edge after the list fills.
   int entered[$];
   bit pending;
   int lock_left, idle_cnt, fails;
   bit m_match, m_fail;
   int n_match = 0;

   function automatic bit entry_ok();
      logic [15:0] pw = PASSWORD;
      for (int i = 0; i < int'(PW_LEN); i++)
         if (entered[i] != int'(pw[DIGIT_W*(int'(PW_LEN)-1-i) +: DIGIT_W])) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or posedge countReset) begin
      if (countReset) begin
         entered.delete();
         pending = 0; lock_left = 0; idle_cnt = 0; fails = 0; m_match = 0; m_fail = 0;
      end else begin
         m_match = 0;
         m_fail  = 0;
         if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
         end else if (pending) begin
            pending = 0;
            if (entry_ok()) begin
               m_match = 1;
               fails = 0;
            end else begin
               m_fail = 1;
               fails++;
               if (fails == int'(MAX_FAILS)) lock_left = LOCKOUT_CYCLES;
            end
            entered.delete();
            idle_cnt = 0;
         end else if (bus.clear) begin
            entered.delete();
            idle_cnt = 0;
         end else if (bus.digit_valid) begin
            entered.push_back(int'(bus.digit));
            idle_cnt = 0;
            if (entered.size() == int'(PW_LEN)) pending = 1;
         end else if (entered.size() > 0) begin
            idle_cnt++;
            if (idle_cnt == int'(ENTRY_TIMEOUT)) begin
               entered.delete();
               idle_cnt = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!countReset) begin
         chk("match_pulse", int'(bus.match_pulse), int'(m_match));
         chk("fail_pulse", int'(bus.fail_pulse), int'(m_fail));
         chk("locked", int'(bus.locked), int'(lock_left > 0));
         chk("digit_count", int'(bus.digit_count), entered.size());
         chk("fail_count", int'(bus.fail_count), fails);
         if (bus.match_pulse) n_match++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put(input int d);
      bus.digit_valid = 1'b1;
      bus.digit = DIGIT_W'(d);
      step(1);
      bus.digit_valid = 1'b0;
   endtask

   task automatic entry(input int a, input int b, input int c, input int d);
      put(a); put(b); put(c); put(d);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int saved;
      bus.digit_valid = 1'b0;
      bus.digit = '0;
      bus.clear = 1'b0;
      step(3);
      chk("reset_match", int'(bus.match_pulse), 0);
      chk("reset_fail", int'(bus.fail_pulse), 0);
      chk("reset_locked", int'(bus.locked), 0);
      chk("reset_count", int'(bus.digit_count), 0);
      chk("reset_fails", int'(bus.fail_count), 0);
      countReset = 1'b0;
      step(2);

      // Correct entry
      put(1); chk("ok_dc1", int'(bus.digit_count), 1);
      put(2); chk("ok_dc2", int'(bus.digit_count), 2);
      put(3); chk("ok_dc3", int'(bus.digit_count), 3);
      put(4); chk("ok_dc4", int'(bus.digit_count), 4);
      chk("ok_no_early_match", int'(bus.match_pulse), 0);
      step(1); chk("ok_match", int'(bus.match_pulse), 1);
      chk("ok_fails0", int'(bus.fail_count), 0);
      step(1); chk("ok_match_end", int'(bus.match_pulse), 0);

      // Wrong entry, then correct
      entry(1, 2, 3, 5); step(1);
      chk("bad_fail", int'(bus.fail_pulse), 1);
      chk("bad_nomatch", int'(bus.match_pulse), 0);
      chk("bad_fails1", int'(bus.fail_count), 1);
      step(1);
      entry(1, 2, 3, 4); step(1);
      chk("fix_match", int'(bus.match_pulse), 1);
      chk("fix_fails0", int'(bus.fail_count), 0);
      step(1);

      // Lockout after three failures
      entry(9, 9, 9, 9); step(2);
      entry(9, 9, 9, 9); step(2);
      chk("lk_fails2", int'(bus.fail_count), 2);
      entry(9, 9, 9, 9); step(1);
      chk("lk_fail3", int'(bus.fail_pulse), 1);
      chk("lk_locked", int'(bus.locked), 1);
      chk("lk_fails3", int'(bus.fail_count), 3);
      put(1); put(2);
      chk("lk_ignore", int'(bus.digit_count), 0);
      step(997); chk("lk_still", int'(bus.locked), 1);
      step(1); chk("lk_release", int'(bus.locked), 0);
      chk("lk_fails_clr", int'(bus.fail_count), 0);
      entry(1, 2, 3, 4); step(1);
      chk("lk_after_match", int'(bus.match_pulse), 1);
      step(1);

      // Timeout and clear
      put(1); put(2);
      step(499); chk("to_hold", int'(bus.digit_count), 2);
      step(1); chk("to_abort", int'(bus.digit_count), 0);
      chk("to_fails", int'(bus.fail_count), 0);
      step(2);
      put(1);
      bus.digit_valid = 1'b1; bus.digit = 4'd2; bus.clear = 1'b1;
      step(1);
      bus.digit_valid = 1'b0; bus.clear = 1'b0;
      chk("clr_dc", int'(bus.digit_count), 0);
      entry(1, 2, 3, 4); step(1);
      chk("clr_match", int'(bus.match_pulse), 1);
      step(1);

      // Gap tolerance: 499 idle cycles between digits
      put(1); step(499); put(2); step(499); put(3); step(499); put(4);
      chk("gap_dc4", int'(bus.digit_count), 4);
      step(1); chk("gap_match", int'(bus.match_pulse), 1);
      step(1);

      // Reset during CHECK suppresses the pulse
      saved = n_match;
      entry(1, 2, 3, 4);
      #2 countReset = 1'b1;
      #1 chk("rst_chk_dc", int'(bus.digit_count), 0);
      chk("rst_chk_match", int'(bus.match_pulse), 0);
      @(posedge clk); #1 countReset = 1'b0;
      step(3);
      chk("rst_chk_nopulse", n_match, saved);

      // Reset during LOCKOUT cancels it
      entry(9, 9, 9, 9); step(1);
      entry(9, 9, 9, 9); step(1);
      entry(9, 9, 9, 9); step(1);
      step(10); chk("rst_lk_pre", int'(bus.locked), 1);
      #2 countReset = 1'b1;
      #1 chk("rst_lk_locked", int'(bus.locked), 0);
      chk("rst_lk_fails", int'(bus.fail_count), 0);
      @(posedge clk); #1 countReset = 1'b0;
      step(3); chk("rst_lk_after", int'(bus.locked), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/pw_sequence_detector.md
Name: pw_sequence_detector

Overview:
- Accepts password digits one at a time as single-cycle strobes from the debounced keypad/switch front end.
- Compares the entered sequence against a parameterised stored password and issues a one-cycle match or fail pulse.
- After repeated failures, enforces a timed lockout.
- match_pulse drives the trigger input of the downstream pulse-stretching stage that holds the unlock/LED indication.

Parameters:
- PW_LEN, 4: number of digits in the password (>=1).
- DIGIT_W, 4: width of one digit.
- PASSWORD, 16'h1234: stored password, PW_LEN*DIGIT_W bits; the first digit entered is the most-significant digit.
- MAX_FAILS, 3: consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 1000: lockout duration in clk cycles (>=1).
- ENTRY_TIMEOUT, 500: maximum idle clk cycles between digits before a partial entry is abandoned (>=1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- countReset  input  1  reset, asynchronous, active-high.
- digit_valid  input  1  single-cycle strobe; digit is sampled on every clk edge where this is high.
- digit  input  DIGIT_W  entered digit value.
- clear  input  1  abort the current entry.
- match_pulse  output  1  one-cycle pulse on a correct full entry.
- fail_pulse  output  1  one-cycle pulse on an incorrect full entry.
- locked  output  1  high during lockout.
- digit_count  output  clog2(PW_LEN+1)  digits accepted in the current entry.
- fail_count  output  clog2(MAX_FAILS+1)  consecutive failures so far.

Behaviour:
- Reset (async, countReset=1):
  - State=IDLE.
  - All outputs 0; mismatch flag, timeout counter and lockout counter cleared.
- All outputs are registered.
- States: IDLE, ENTRY, CHECK, LOCKOUT.
- IDLE:
  - digit_valid=1 → compare digit with password digit 0 and set mismatch if they differ; digit_count=1.
  - Next state is ENTRY, or CHECK if PW_LEN==1.
- ENTRY:
  - digit_valid=1 → compare digit with password digit [digit_count]; mismatch is ORed (sticky); digit_count+1; timeout counter cleared.
  - When the incremented count equals PW_LEN, go to CHECK.
  - No digit for ENTRY_TIMEOUT consecutive cycles → IDLE; digit_count=0, mismatch=0, no fail recorded.
- Comparison: all PW_LEN digits are always collected. No early reject, so timing does not leak the mismatch position.
- CHECK (exactly one cycle):
  - mismatch=0 → match_pulse=1, fail_count=0, go to IDLE.
  - mismatch=1 → fail_pulse=1, fail_count+1. Go to LOCKOUT with locked=1 if the new fail_count==MAX_FAILS, else IDLE.
  - digit_count and mismatch are cleared on leaving CHECK.
  - digit_valid and clear are ignored during CHECK.
- Latency: the edge sampling the final digit enters CHECK. The next edge asserts match_pulse or fail_pulse. The edge after that deasserts it. Pulses are never longer than 1 cycle.
- LOCKOUT:
  - digit_valid and clear are ignored; digit_count stays 0.
  - Lockout counter increments each cycle. After LOCKOUT_CYCLES cycles in LOCKOUT: locked=0, fail_count=0, go to IDLE.
- clear in IDLE or ENTRY: go to IDLE; digit_count=0, mismatch=0, timeout counter cleared. If digit_valid is high in the same cycle, clear wins and the digit is discarded.
- digit_valid held high for k cycles counts as k digits; upstream guarantees single-cycle strobes.
- countReset asserted mid-entry, in CHECK or in LOCKOUT: immediate return to the reset state; a pending pulse is suppressed and the lockout is cancelled.
- Counters saturate and never wrap:
  - Timeout counter stops at ENTRY_TIMEOUT.
  - fail_count never exceeds MAX_FAILS.

Test Plan:
- Correct entry: digits 1,2,3,4 on consecutive cycles → digit_count steps 1..4. match_pulse is high for exactly 1 cycle, 2 edges after digit 4. fail_count=0.
- Wrong entry: 1,2,3,5 → fail_pulse for 1 cycle, fail_count=1, no match_pulse. Then 1,2,3,4 → match_pulse and fail_count=0.
- Lockout:
  - Three wrong entries (e.g. 9,9,9,9) → third fail_pulse, and locked=1 on the same edge.
  - Digits during lockout are ignored.
  - locked falls after exactly 1000 cycles with fail_count=0.
  - 1,2,3,4 afterwards → match_pulse.
- Timeout/clear:
  - Enter 1,2, then idle 500 cycles → digit_count=0, no pulse, fail_count unchanged.
  - Enter 1, then assert clear together with digit_valid(2) → digit_count=0.
  - Then 1,2,3,4 → match_pulse.
- Async reset: assert countReset between clk edges in the cycle after digit 4 (CHECK) → outputs 0 immediately, no match_pulse ever appears. Repeat during LOCKOUT → locked=0 at once.
- Gap tolerance: 1,2,3,4 with 499 idle cycles between digits → match_pulse (timeout boundary not triggered).
